// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the arbiter state encoding, the default data-streak limit and a
// helper that sizes the streak counter.
package mem_arb_pkg;

  // Default number of back-to-back data grants tolerated while an
  // instruction request is waiting.
  localparam int unsigned MAX_DSTREAK_DEFAULT = 32'd3;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Width of the streak counter; at least one bit so that a limit of zero
  // still yields a legal (always-zero) register.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    if (max_streak > 32'd0) begin
      return $clog2(max_streak + 32'd1);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester channels and the shared memory port.
// The arbiter uses the slave view; the requesters/memory model use master.
interface mem_port_arbiter_if;

  // Instruction refill requester
  logic        ireq_i;
  logic [31:0] iaddr_i;
  logic [31:0] irdata_o;
  logic        iready_o;

  // Data requester
  logic        dreq_i;
  logic        dwe_i;
  logic [31:0] daddr_i;
  logic [31:0] dwdata_i;
  logic [31:0] drdata_o;
  logic        dready_o;

  // Shared memory port
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport slave (
    input  ireq_i, iaddr_i,
    input  dreq_i, dwe_i, daddr_i, dwdata_i,
    input  mem_rdata_i, mem_ack_i,
    output irdata_o, iready_o,
    output drdata_o, dready_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output ireq_i, iaddr_i,
    output dreq_i, dwe_i, daddr_i, dwdata_i,
    output mem_rdata_i, mem_ack_i,
    input  irdata_o, iready_o,
    input  drdata_o, dready_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_port_arbiter_arb_priority.sv
// Tie-break between instruction and data requests with anti-starvation.
// Data normally wins a tie, but once MAX_DSTREAK data grants have been made
// in a row while an instruction request waited, the instruction side wins.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ireq_i,
  input  logic dreq_i,
  input  logic grant_i,
  output logic grant_d
);

  localparam int unsigned      SW         = streak_width(MAX_DSTREAK);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          at_limit;

  // Decide the winner: data unless the waiting instruction has hit its limit.
  always_comb begin
    at_limit = (streak_q == STREAK_MAX);
    grant_d  = dreq_i & ~(ireq_i & at_limit);
  end

  // Count data grants that overtook a pending instruction request.
  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      if (grant_d && ireq_i) begin
        if (at_limit) begin
          streak_d = streak_q;
        end else begin
          streak_d = streak_q + SW'(1'b1);
        end
      end else begin
        // Instruction grant, or data grant with nobody waiting.
        streak_d = {SW{1'b0}};
      end
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      streak_q <= {SW{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single memory port.
// One access at a time: grant in IDLE, hold the port in BUSY_I/BUSY_D until
// the memory acknowledges, then spend one RESP cycle pulsing the ready of the
// requester that owned the access. All outputs come straight from flops.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        iready_q, iready_d;
  logic        dready_q, dready_d;

  logic        grant_strobe;
  logic        grant_d;

  arb_priority #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_arb_priority (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .ireq_i  (bus.ireq_i),
    .dreq_i  (bus.dreq_i),
    .grant_i (grant_strobe),
    .grant_d (grant_d)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    iready_d     = 1'b0;
    dready_d     = 1'b0;
    grant_strobe = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ireq_i || bus.dreq_i) begin
          grant_strobe = 1'b1;
          mem_req_d    = 1'b1;
          if (grant_d) begin
            state_d     = BUSY_D;
            mem_we_d    = bus.dwe_i;
            mem_addr_d  = bus.daddr_i;
            mem_wdata_d = bus.dwdata_i;
          end else begin
            // Fetches are always reads with no payload.
            state_d     = BUSY_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.iaddr_i;
            mem_wdata_d = 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end

      BUSY_I: begin
        if (bus.mem_ack_i) begin
          state_d     = RESP;
          irdata_d    = bus.mem_rdata_i;
          iready_d    = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wdata_d = 32'h0000_0000;
        end else begin
          state_d = BUSY_I;
        end
      end

      BUSY_D: begin
        if (bus.mem_ack_i) begin
          // Stores capture the bus too; the value is simply unused.
          state_d     = RESP;
          drdata_d    = bus.mem_rdata_i;
          dready_d    = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wdata_d = 32'h0000_0000;
        end else begin
          state_d = BUSY_D;
        end
      end

      RESP: begin
        // Requests are deliberately not sampled here.
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'h0000_0000;
        mem_wdata_d = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      irdata_q    <= 32'h0000_0000;
      drdata_q    <= 32'h0000_0000;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.irdata_o    = irdata_q;
  assign bus.iready_o    = iready_q;
  assign bus.drdata_o    = drdata_q;
  assign bus.dready_o    = dready_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DSTREAK, default 3: the maximum number of consecutive data grants allowed while an instruction request waits.
REQ-002 clk_i  in  1  system clock; all state updates on its rising edge.
REQ-003 rst_ni  in  1  reset, synchronous and active-low.
REQ-004 ireq_i  in  1  instruction-fetch refill request; held high until iready_o is seen.
REQ-005 iaddr_i  in  32  instruction address; stable while ireq_i is high.
REQ-006 irdata_o  out  32  instruction read data; valid while iready_o is high.
REQ-007 iready_o  out  1  one-cycle completion pulse for the instruction requester.
REQ-008 dreq_i  in  1  data-memory request; held high until dready_o is seen.
REQ-009 dwe_i  in  1  data write enable (1 = store, 0 = load).
REQ-010 daddr_i / dwdata_i  in  32 / 32  data address and store data.
REQ-011 drdata_o  out  32  load data; valid while dready_o is high.
REQ-012 dready_o  out  1  one-cycle completion pulse for the data requester.
REQ-013 mem_req_o, mem_we_o  out  1, 1  shared memory port request and write enable.
REQ-014 mem_addr_o, mem_wdata_o  out  32, 32  shared port address and write data.
REQ-015 mem_rdata_i  in  32  read data from the shared port; valid with mem_ack_i.
REQ-016 mem_ack_i  in  1  access-complete strobe from the shared port.

Function
REQ-017 The FSM SHALL have four states: IDLE, BUSY_I, BUSY_D and RESP.
- IDLE: samples the requests.
- BUSY_I / BUSY_D: an access is outstanding.
- RESP: the single cycle in which the ready pulse is driven.
REQ-018 In IDLE with only one request high, the FSM SHALL grant that requester: go to BUSY_I or BUSY_D on the next edge.
REQ-019 In IDLE with both requests high, the FSM SHALL grant data, unless streak == MAX_DSTREAK; in that case it SHALL grant instruction.
REQ-020 In IDLE with no requests, the FSM SHALL stay in IDLE with every output low.
REQ-021 On a grant, the block SHALL latch address, we and wdata from the granted requester. Instruction grants SHALL latch we = 0 and wdata = 0.
REQ-022 In a BUSY state:
- mem_req_o SHALL be 1, and the mem_* outputs SHALL show the latched values, constant until ack.
- Requester inputs SHALL be ignored.
REQ-023 On a BUSY cycle with mem_ack_i = 1, the block SHALL register mem_rdata_i into irdata_o or drdata_o and go to RESP. mem_req_o SHALL be 0 from the next cycle.
REQ-024 In RESP, exactly one of iready_o or dready_o SHALL be 1, matching the grant; the next state SHALL be IDLE unconditionally.
REQ-025 Requests seen in RESP SHALL be ignored, so the requester can drop req in the ready cycle.
REQ-026 Minimum latency SHALL be: grant at IDLE cycle t, mem_req_o high at t+1, ack earliest at t+1, ready at t+2. A request therefore takes at least 3 cycles from IDLE back to IDLE.
REQ-027 The ack wait SHALL be unbounded (no timeout). mem_ack_i SHALL be ignored outside the BUSY states.
REQ-028 A drop of ireq_i or dreq_i during BUSY SHALL NOT abort the access; the ready pulse is still issued.
REQ-029 irdata_o and drdata_o SHALL hold their last captured value until the next capture for the same requester. Stores SHALL also capture mem_rdata_i (don't-care data).
REQ-030 Counter streak, $clog2(MAX_DSTREAK+1) bits, SHALL update as follows:
- +1 on a data grant with ireq_i = 1, saturating at MAX_DSTREAK.
- Reset to 0 on an instruction grant.
- Reset to 0 on a data grant with ireq_i = 0.
REQ-031 If MAX_DSTREAK = 0, an instruction request SHALL always win ties.

Reset
REQ-032 When rst_ni = 0 at a clock edge, the next state SHALL be:
- State: IDLE.
- Counter: streak = 0.
- Outputs: all control outputs and latched registers 0, including irdata_o and drdata_o.
REQ-033 A reset during BUSY or RESP SHALL abandon the access: no ready pulse, mem_req_o = 0 from the next cycle. A late mem_ack_i SHALL be ignored.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY_I, BUSY_D, RESP) and the default MAX_DSTREAK constant.
REQ-035 The tie-break and streak counter SHALL be one sub-module, arb_priority: inputs are the two requests and the grant strobe; output is grant_d.

Verification
REQ-036 Single load: dreq=1, dwe=0, daddr=0x100; ack 2 cycles after mem_req_o rises with rdata=0xDEADBEEF. Required: dready_o pulses 1 cycle, drdata_o=0xDEADBEEF, mem_req_o low afterwards.
REQ-037 Store: dwe=1, daddr=0x20, dwdata=0x12345678. Required: mem_we_o=1 and mem_wdata_o=0x12345678 held until ack; iready_o stays 0.
REQ-038 Tie: ireq and dreq both high from IDLE, MAX_DSTREAK=3. Required: D granted first, then I.
REQ-039 Starvation: ireq held high, dreq re-asserted immediately after each dready_o. Required: grants D,D,D,I, then D resumes.
REQ-040 Reset in BUSY_D, with ack arriving the cycle after reset. Required: no dready_o, state IDLE, streak=0.
REQ-041 Requester drops dreq mid-BUSY. Required: access completes and dready_o still pulses once.
